// File: rtl/motor_cmd_pkg.sv
// Shared constants and types for the command decoder / wheel ramp slice.
package motor_cmd_pkg;

  localparam int unsigned DRV_W = 11;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_FWD  = 2'b01;
  localparam logic [1:0] OP_REV  = 2'b10;
  localparam logic [1:0] OP_SPIN = 2'b11;

  // Speed field to drive magnitude scaling
  localparam int unsigned FWD_SHIFT  = 4;
  localparam int unsigned SPIN_SHIFT = 5;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    CRUISE,
    PAUSE
  } state_t;

endpackage

// File: rtl/motor_cmd_ramp_axis.sv
// One wheel's slew-rate limiter: on each tick, move cur toward target by at most RAMP_STEP.
module ramp_axis
  import motor_cmd_pkg::*;
#(
  parameter int unsigned RAMP_STEP = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic signed [DRV_W-1:0] target,
  output logic signed [DRV_W-1:0] cur,
  output logic                    at_tgt
);

  localparam logic signed [DRV_W:0]   STEP_W = (DRV_W + 1)'(RAMP_STEP);
  localparam logic signed [DRV_W-1:0] STEP_D = DRV_W'(RAMP_STEP);

  logic signed [DRV_W:0]   diff;
  logic signed [DRV_W:0]   mag;
  logic signed [DRV_W-1:0] cur_nxt;

  // One extra bit so the full -1008..+1008 swing cannot overflow
  always_comb begin
    diff = {target[DRV_W-1], target} - {cur[DRV_W-1], cur};
    mag  = diff[DRV_W] ? -diff : diff;
    if (mag <= STEP_W) begin
      cur_nxt = target;
    end else if (diff[DRV_W]) begin
      cur_nxt = cur - STEP_D;
    end else begin
      cur_nxt = cur + STEP_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= '0;
    end else if (tick) begin
      cur <= cur_nxt;
    end
  end

  assign at_tgt = (cur == target);

endmodule

// File: rtl/motor_cmd_ramp.sv
// Command byte handshake/decoder, ramp tick divider, command timeout and motion FSM
// driving two slew-limited wheel outputs toward motor_cntrl.
module motor_cmd_ramp
  import motor_cmd_pkg::*;
#(
  parameter int unsigned RAMP_DIV      = 50000,
  parameter int unsigned RAMP_STEP     = 8,
  parameter int unsigned TIMEOUT_TICKS = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              cmd,
  input  logic                    cmd_rdy,
  output logic                    clr_cmd_rdy,
  input  logic                    OK2Move,
  output logic signed [DRV_W-1:0] lft,
  output logic signed [DRV_W-1:0] rht,
  output logic                    in_transit
);

  localparam int unsigned DIV_W = $clog2(RAMP_DIV);
  localparam int unsigned TO_W  = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  logic [DIV_W-1:0]        div_cnt;
  logic                    tick;
  logic                    busy;
  logic                    accept;
  logic [TO_W-1:0]         to_cnt;
  logic                    to_hit;
  state_t                  state;
  logic signed [DRV_W-1:0] tgt_l, tgt_r;
  logic signed [DRV_W-1:0] eff_l, eff_r;
  logic signed [DRV_W-1:0] dec_l, dec_r;
  logic signed [DRV_W-1:0] mag_fr, mag_sp;
  logic                    dec_nz;
  logic                    at_l, at_r;

  // Free-running ramp tick divider
  assign tick = (div_cnt == DIV_W'(RAMP_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // busy masks the receiver's still-high cmd_rdy during the clear cycle
  assign accept      = cmd_rdy & ~busy;
  assign clr_cmd_rdy = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= accept;
    end
  end

  always_comb begin
    mag_fr = DRV_W'(cmd[5:0]) << FWD_SHIFT;
    mag_sp = DRV_W'(cmd[4:0]) << SPIN_SHIFT;
    dec_l  = '0;
    dec_r  = '0;
    case (cmd[7:6])
      OP_FWD: begin
        dec_l = mag_fr;
        dec_r = mag_fr;
      end
      OP_REV: begin
        dec_l = -mag_fr;
        dec_r = -mag_fr;
      end
      OP_SPIN: begin
        dec_l = cmd[5] ? -mag_sp : mag_sp;
        dec_r = cmd[5] ? mag_sp : -mag_sp;
      end
      default: ;
    endcase
    // A zero magnitude field decodes to zero targets, i.e. a STOP
    dec_nz = (dec_l != '0);
  end

  assign to_hit = (TIMEOUT_TICKS != 0) && tick && (state != IDLE) &&
                  (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tgt_l  <= '0;
      tgt_r  <= '0;
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
      tgt_l  <= dec_l;
      tgt_r  <= dec_r;
      if (!dec_nz) begin
        state <= IDLE;
      end else if (state == CRUISE && dec_l == tgt_l && dec_r == tgt_r) begin
        state <= CRUISE;
      end else begin
        state <= OK2Move ? RAMP : PAUSE;
      end
    end else if (to_hit) begin
      to_cnt <= '0;
      tgt_l  <= '0;
      tgt_r  <= '0;
      state  <= IDLE;
    end else begin
      if (tick && state != IDLE) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      case (state)
        RAMP: begin
          if (!OK2Move)         state <= PAUSE;
          else if (at_l && at_r) state <= CRUISE;
        end
        CRUISE: begin
          if (!OK2Move)            state <= PAUSE;
          else if (!(at_l && at_r)) state <= RAMP;
        end
        PAUSE: begin
          if (OK2Move) state <= RAMP;
        end
        default: ;
      endcase
    end
  end

  assign in_transit = (state != IDLE);

  // Proximity block is applied per tick without latching
  assign eff_l = OK2Move ? tgt_l : '0;
  assign eff_r = OK2Move ? tgt_r : '0;

  ramp_axis #(
    .RAMP_STEP(RAMP_STEP)
  ) u_axis_l (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .target(eff_l),
    .cur   (lft),
    .at_tgt(at_l)
  );

  ramp_axis #(
    .RAMP_STEP(RAMP_STEP)
  ) u_axis_r (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .target(eff_r),
    .cur   (rht),
    .at_tgt(at_r)
  );

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Directed bench for motor_cmd_ramp with RAMP_DIV=4, RAMP_STEP=8, TIMEOUT_TICKS=10.
module tb_motor_cmd_ramp;
  import motor_cmd_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        cmd = 8'h00;
  logic              cmd_rdy = 1'b0;
  logic              clr_cmd_rdy;
  logic              OK2Move = 1'b1;
  logic signed [10:0] lft, rht;
  logic              in_transit;

  int n_checks = 0;
  int n_errors = 0;
  int m = 0;          // bench copy of the tick divider phase
  int el = 0, er = 0; // expected wheel values
  int pulses;

  motor_cmd_ramp #(
    .RAMP_DIV     (4),
    .RAMP_STEP    (8),
    .TIMEOUT_TICKS(10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .OK2Move    (OK2Move),
    .lft        (lft),
    .rht        (rht),
    .in_transit (in_transit)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) m <= 0;
    else     m <= (m == 3) ? 0 : m + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic int step(input int c, input int t);
    if ((t - c) <= 8 && (c - t) <= 8) return t;
    else if (t > c) return c + 8;
    else return c - 8;
  endfunction

  // Park at a falling edge where the divider phase equals v
  task automatic align(input int v);
    int n = 0;
    while (!(clk === 1'b0 && m == v) && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) check("align_timeout", 0, 1);
  endtask

  task automatic next_tick();
    align(3);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    align(0);
    cmd     = b;
    cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("clr_pulse", clr_cmd_rdy, 1);
    @(posedge clk);
    #1;
    check("clr_drop", clr_cmd_rdy, 0);
    cmd_rdy = 1'b0;
  endtask

  task automatic ramp_ticks(input logic [7:0] b, input int tl, input int tr, input int n);
    for (int i = 1; i <= n; i++) begin
      next_tick();
      el = step(el, tl);
      er = step(er, tr);
      check("lft", lft, el);
      check("rht", rht, er);
      if (i % 5 == 0 && i < n) send(b);
    end
  endtask

  task automatic ramp_seq(input logic [7:0] b, input int tl, input int tr, input int n);
    send(b);
    ramp_ticks(b, tl, tr, n);
  endtask

  task automatic expect_state(input string tag, input state_t s);
    check(tag, int'(dut.state), int'(s));
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_lft", lft, 0);
    check("rst_rht", rht, 0);
    check("rst_clr", clr_cmd_rdy, 0);
    check("rst_transit", in_transit, 0);
    expect_state("rst_state", IDLE);
    rst = 1'b0;

    // FWD speed 4: 8,16,...,64 then CRUISE
    send(8'h44);
    check("fwd_transit", in_transit, 1);
    expect_state("fwd_ramp", RAMP);
    ramp_ticks(8'h44, 64, 64, 8);
    check("fwd_final", lft, 64);
    @(posedge clk); #1;
    expect_state("fwd_cruise", CRUISE);

    // cmd_rdy held across the busy cycle: one pulse only
    align(0);
    cmd = 8'h44;
    cmd_rdy = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pulses += int'(clr_cmd_rdy);
      if (i == 0) check("busy_set", dut.busy, 1);
      if (i == 1) begin
        check("busy_clr", dut.busy, 0);
        cmd_rdy = 1'b0;
      end
    end
    check("one_pulse", pulses, 1);
    expect_state("hold_cruise", CRUISE);

    // REV speed 4: through zero to -64, no overshoot
    ramp_seq(8'h84, -64, -64, 17);
    @(posedge clk); #1;
    expect_state("rev_cruise", CRUISE);

    // FWD full scale clamps at 1008
    ramp_seq(8'h7F, 1008, 1008, 136);
    check("max_lft", lft, 1008);
    @(posedge clk); #1;
    expect_state("max_cruise", CRUISE);

    // SPIN dir 1 mag 32: left -32, right +32
    ramp_seq(8'hE1, -32, 32, 131);
    @(posedge clk); #1;
    expect_state("spin_cruise", CRUISE);

    // Proximity block: ramp to 0, PAUSE
    align(0);
    OK2Move = 1'b0;
    ramp_seq(8'hE1, 0, 0, 4);
    expect_state("pause", PAUSE);
    check("pause_transit", in_transit, 1);

    // Permit restored: back to -32/+32
    align(0);
    OK2Move = 1'b1;
    ramp_seq(8'hE1, -32, 32, 4);
    @(posedge clk); #1;
    expect_state("resume_cruise", CRUISE);

    // Timeout: 10 ticks with no byte forces STOP
    send(8'hE1);
    for (int i = 1; i <= 9; i++) next_tick();
    check("to_before", in_transit, 1);
    next_tick();
    check("to_after", in_transit, 0);
    check("to_lft_hold", lft, -32);
    ramp_ticks(8'h00, 0, 0, 4);
    check("to_idle_transit", in_transit, 0);

    // Byte landing on the timeout edge keeps motion
    ramp_seq(8'h44, 64, 64, 8);
    send(8'h44);
    for (int i = 1; i <= 9; i++) next_tick();
    align(3);
    cmd = 8'h44;
    cmd_rdy = 1'b1;
    @(posedge clk); #1;
    check("to_edge_clr", clr_cmd_rdy, 1);
    check("to_edge_transit", in_transit, 1);
    @(posedge clk); #1;
    cmd_rdy = 1'b0;
    for (int i = 1; i <= 9; i++) next_tick();
    check("to_edge_later", in_transit, 1);
    check("to_edge_lft", lft, 64);

    // Reset mid-ramp, during a clear pulse
    ramp_seq(8'h7F, 1008, 1008, 3);
    align(0);
    cmd = 8'h7F;
    cmd_rdy = 1'b1;
    @(posedge clk); #1;
    check("mid_clr", clr_cmd_rdy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_lft", lft, 0);
    check("mid_rst_rht", rht, 0);
    check("mid_rst_clr", clr_cmd_rdy, 0);
    check("mid_rst_transit", in_transit, 0);
    cmd_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    el = 0;
    er = 0;
    ramp_ticks(8'h00, 0, 0, 3);
    check("post_rst_transit", in_transit, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
